// File: rtl/tt_um_result_buf.sv
// Result buffer: requantizes signed multiplier results (round, shift, optional
// ReLU, saturate) in a one-cycle stage register. The results then go into a
// first-word-fall-through FIFO that a downstream consumer drains with a
// valid/ready handshake.
module tt_um_result_buf #(
  parameter int AccWidth = 12,
  parameter int BitWidth = 8,
  parameter int Depth    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      flush,
  input  logic                      cfg_relu,
  input  logic [3:0]                cfg_shift,
  input  logic                      in_valid,
  input  logic [AccWidth-1:0]       in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BitWidth-1:0]       out_data,
  output logic                      out_last,
  output logic [$clog2(Depth):0]    count,
  output logic                      overflow
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  // Largest shift that still leaves the sign bit meaningful.
  localparam logic [3:0] MaxShift = (AccWidth - 1 > 15) ? 4'd15 : 4'(AccWidth - 1);

  // Saturation bounds, held in the AccWidth+1 bit working width.
  localparam logic signed [AccWidth:0] SatMax = (AccWidth + 1)'((2 ** (BitWidth - 1)) - 1);
  localparam logic signed [AccWidth:0] SatMin = (AccWidth + 1)'(-(2 ** (BitWidth - 1)));

  // FIFO storage: the last flag is kept in the top bit of each entry.
  logic [BitWidth:0] mem [Depth];

  logic [PtrW-1:0]     wr_ptr_reg;
  logic [PtrW-1:0]     rd_ptr_reg;
  logic [CntW-1:0]     count_reg;
  logic                stage_valid_reg;
  logic [BitWidth-1:0] stage_data_reg;
  logic                stage_last_reg;
  logic                overflow_reg;

  logic [CntW:0]       occupancy;
  logic                in_xfer;
  logic                fifo_push;
  logic                fifo_pop;
  logic [BitWidth:0]   head_entry;

  logic [3:0]                 shift_amt;
  logic signed [AccWidth:0]   acc_ext;
  logic signed [AccWidth:0]   rnd_const;
  logic signed [AccWidth:0]   summed;
  logic signed [AccWidth:0]   shifted;
  logic signed [AccWidth:0]   relu_val;
  logic [BitWidth-1:0]        sat_val;

  // The stage register always drains into the FIFO on the next cycle. So
  // counting it together with the FIFO entries guarantees the FIFO has room
  // for the stage contents.
  assign occupancy = {1'b0, count_reg} + (CntW + 1)'(stage_valid_reg);

  // Acceptance is also gated by rst_n so that in_ready reads 0 while reset is asserted.
  assign in_ready  = rst_n && ena && !flush && (occupancy < (CntW + 1)'(Depth));
  assign in_xfer   = in_valid && in_ready;

  assign out_valid = (count_reg != '0);
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = stage_valid_reg;

  assign head_entry = mem[rd_ptr_reg];
  assign out_data   = out_valid ? head_entry[BitWidth-1:0] : '0;
  assign out_last   = out_valid ? head_entry[BitWidth] : 1'b0;
  assign count      = count_reg;
  assign overflow   = overflow_reg;

  // Requantization datapath: round-half-up, arithmetic shift, ReLU, saturate.
  always_comb begin
    shift_amt = (cfg_shift > MaxShift) ? MaxShift : cfg_shift;
    acc_ext   = {in_data[AccWidth-1], in_data};
    rnd_const = '0;
    if (shift_amt != 4'd0) begin
      rnd_const = (AccWidth + 1)'(1) << (shift_amt - 4'd1);
    end
    summed   = acc_ext + rnd_const;
    shifted  = summed >>> shift_amt;
    relu_val = (cfg_relu && shifted[AccWidth]) ? '0 : shifted;
    if (relu_val > SatMax) begin
      sat_val = SatMax[BitWidth-1:0];
    end else if (relu_val < SatMin) begin
      sat_val = SatMin[BitWidth-1:0];
    end else begin
      sat_val = relu_val[BitWidth-1:0];
    end
  end

  // Stage register: captures the requantized value on each input transfer.
  // The configuration is applied here, so later changes to it leave
  // in-flight data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_reg <= 1'b0;
      stage_data_reg  <= '0;
      stage_last_reg  <= 1'b0;
    end else if (flush) begin
      stage_valid_reg <= 1'b0;
    end else begin
      stage_valid_reg <= in_xfer;
      if (in_xfer) begin
        stage_data_reg <= sat_val;
        stage_last_reg <= in_last;
      end
    end
  end

  // FIFO pointers and occupancy count. Flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage write. The array has no reset; an entry is only visible
  // when count says so.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem[wr_ptr_reg] <= {stage_last_reg, stage_data_reg};
    end
  end

  // Sticky overflow: an enabled offer that could not be accepted was dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (flush) begin
      overflow_reg <= 1'b0;
    end else if (in_valid && !in_ready && ena) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tt_um_result_buf.sv
// Scoreboard bench for tt_um_result_buf. The driver pushes expected results
// computed from the arithmetic rules. A negedge monitor checks the output
// side and pops entries as they transfer.
module tb_tt_um_result_buf;
  localparam int AW = 12;
  localparam int BW = 8;
  localparam int D  = 16;
  localparam int SMAX = (1 << (BW - 1)) - 1;
  localparam int SMIN = -(1 << (BW - 1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          flush = 1'b0;
  logic          cfg_relu = 1'b0;
  logic [3:0]    cfg_shift = 4'd0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic [$clog2(D):0] count;
  logic          overflow;

  tt_um_result_buf #(.AccWidth(AW), .BitWidth(BW), .Depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush),
    .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
    int            avail;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   ovf_cur = 1'b0;
  bit   ovf_next = 1'b0;
  bit   flush_pend = 1'b0;
  bit   release_pend = 1'b0;

  // Reference requantization from the plain arithmetic rules.
  function automatic logic [BW-1:0] ref_q(int x, bit relu, int sh);
    int s;
    int r;
    int y;
    s = (sh > AW - 1) ? AW - 1 : sh;
    r = (s == 0) ? 0 : (1 << (s - 1));
    y = (x + r) >>> s;
    if (relu && y < 0) y = 0;
    if (y > SMAX) y = SMAX;
    if (y < SMIN) y = SMIN;
    return BW'(y);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic step(bit iv, int data, bit last, bit relu, int sh, bit en, bit fl, bit ordy);
    bit   exp_rdy;
    ent_t e;
    @(posedge clk);
    #1;
    if (release_pend) begin
      rst_n = 1'b1;
      release_pend = 1'b0;
    end
    in_valid = iv; in_data = AW'(data); in_last = last;
    cfg_relu = relu; cfg_shift = 4'(sh); ena = en; flush = fl; out_ready = ordy;
    exp_rdy = rst_n && en && !fl && (sb.size() < D);
    #1;
    chk("in_ready", in_ready, exp_rdy);
    if (iv && exp_rdy) begin
      e.d = ref_q(data, relu, sh);
      e.l = last;
      e.avail = cyc + 2;
      sb.push_back(e);
      $display("push cyc=%0d data=%0d relu=%0b shift=%0d last=%0b exp=%0d", cyc, data, relu, sh, last, $signed(e.d));
    end
    ovf_next = fl ? 1'b0 : (ovf_cur | (iv && !exp_rdy && en && rst_n));
    flush_pend = fl;
  endtask

  // Monitor: compares the output side with the scoreboard head each cycle.
  always @(negedge clk) begin : monitor
    bit ev;
    int n;
    ev = (sb.size() > 0) && (sb[0].avail <= cyc);
    n = 0;
    foreach (sb[i]) if (sb[i].avail <= cyc) n++;
    chk("out_valid", out_valid, ev);
    chk("count", count, n);
    chk("overflow", overflow, ovf_cur);
    if (ev) begin
      chk("out_data", out_data, sb[0].d);
      chk("out_last", out_last, sb[0].l);
    end else begin
      chk("out_data_idle", out_data, 0);
      chk("out_last_idle", out_last, 0);
    end
    if (flush_pend) begin
      sb.delete();
    end else if (ev && out_ready) begin
      $display("pop  cyc=%0d data=%0d last=%0b", cyc, $signed(out_data), out_last);
      void'(sb.pop_front());
    end
    ovf_cur = ovf_next;
  end

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    flush_pend = 1'b0;
    ovf_next = ovf_cur;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    sb.delete();
    ovf_cur = 1'b0;
    ovf_next = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // Release reset; the first push lands on the first edge after release.
    release_pend = 1'b1;
    step(1, 7, 0, 0, 2, 1, 0, 1);
    step(1, -6, 1, 0, 2, 1, 0, 1);
    // Changing the configuration must not affect data already captured.
    step(0, 0, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 1, 7, 1, 0, 1);
    step(1, 300, 0, 0, 0, 1, 0, 1);
    step(1, -300, 0, 0, 0, 1, 0, 1);
    step(1, -5, 1, 1, 0, 1, 0, 1);
    step(1, 2047, 0, 0, 15, 1, 0, 1);
    step(1, -2048, 0, 0, 15, 1, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0, 1);

    // Fill with the output stalled: 16 stored, the rest dropped, overflow sticks.
    for (int i = 0; i < 20; i++) step(1, i * 37 - 300, (i % 4) == 3, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 1);

    // Full throughput with last on every 8th element.
    for (int i = 0; i < 40; i++)
      step(1, int'($urandom_range(0, 4095)) - 2048, (i % 8) == 7, 0, 3, 1, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0, 1);

    // Flush while holding 5 entries with the stage register writing at the same edge.
    for (int i = 0; i < 5; i++) step(1, i * 50, 0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 99, 1, 0, 0, 1, 0, 0);
    step(1, 55, 0, 0, 0, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)), $urandom_range(0, 7) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
    repeat (24) step(0, 0, 0, 0, 0, 1, 0, 1);

    // Reset between edges while holding 3 entries.
    for (int i = 0; i < 3; i++) step(1, 10 + i, 0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);
    mid_reset();
    repeat (2) step(1, 1, 0, 0, 0, 1, 0, 1);
    release_pend = 1'b1;
    step(0, 0, 0, 0, 0, 1, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 42, 1, 0, 1, 1, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_result_buf.md
TT_UM_RESULT_BUF -- requirements
Module: tt_um_result_buf

Interface
REQ-001 SHALL have parameter AccWidth, default 12, signed width of incoming multiplier result.
REQ-002 SHALL have parameter BitWidth, default 8, width of buffered/output result.
REQ-003 SHALL have parameter Depth, default 16, FIFO entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  block enable; low blocks new input acceptance.
REQ-007 flush  input  1  synchronous clear of pipeline, FIFO and overflow flag.
REQ-008 cfg_relu  input  1  1 = clamp negative results to 0.
REQ-009 cfg_shift  input  4  arithmetic right-shift amount for requantization.
REQ-010 in_valid  input  1  upstream result valid.
REQ-011 in_data  input  AccWidth  signed result from the multiplier stage.
REQ-012 in_last  input  1  marks final element of an output vector.
REQ-013 in_ready  output  1  block can accept in_data this cycle.
REQ-014 out_valid  output  1  out_data holds the FIFO head.
REQ-015 out_ready  input  1  downstream consumes the head.
REQ-016 out_data  output  BitWidth  requantized signed result.
REQ-017 out_last  output  1  in_last carried with the head entry.
REQ-018 count  output  $clog2(Depth)+1  entries currently in the FIFO.
REQ-019 overflow  output  1  sticky flag: input offered while not ready.

Function
REQ-020 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-021 in_ready SHALL equal ena && !flush && (count + stage_valid) < Depth, where stage_valid is the internal requant register's valid bit.
REQ-022 Requant stage, 1 cycle: s = min(cfg_shift, AccWidth-1); r = (s==0) ? 0 : 1<<(s-1); y = (in_data + r) >>> s, computed in AccWidth+1 bits.
REQ-023 If cfg_relu==1 and y<0, y SHALL become 0, applied after shifting.
REQ-024 y SHALL saturate to [-2^(BitWidth-1), 2^(BitWidth-1)-1], e.g. [-128, 127].
REQ-025 cfg_relu and cfg_shift SHALL be sampled on the input transfer cycle; later changes do not affect in-flight data.
REQ-026 Stage register SHALL write into the FIFO the cycle after capture; in_last travels with its data.
REQ-027 Latency: with the FIFO empty, an input transfer at cycle N SHALL give out_valid=1 with that data at cycle N+2.
REQ-028 FIFO SHALL be first-word-fall-through; out_data/out_last SHALL be stable while out_valid && !out_ready.
REQ-029 Simultaneous FIFO write and pop SHALL leave count unchanged; this is legal when full (count==Depth) and when count==1.
REQ-030 Read/write pointers SHALL wrap modulo Depth with no loss or duplication.
REQ-031 When empty, out_valid SHALL be 0; out_data and out_last SHALL be 0.
REQ-032 overflow SHALL set when in_valid && !in_ready && ena && !flush; it stays 1 until flush or reset; the offered data is dropped.
REQ-033 flush SHALL, on the next edge, empty the FIFO, invalidate the stage register and clear overflow; flush takes priority over simultaneous push/pop.
REQ-034 ena low SHALL not stall draining; out side continues independently.

Reset
REQ-035 rst_n low SHALL immediately (asynchronously) clear pointers, count, stage valid and overflow.
REQ-036 During reset: in_ready=0, out_valid=0, out_data=0, out_last=0, count=0, overflow=0.
REQ-037 Reset mid-transfer SHALL discard all buffered data; no entry appears after deassertion.
REQ-038 First input SHALL be accepted on the first rising edge after rst_n deasserts, if ena=1.

Verification
REQ-039 Shift/round: cfg_shift=2, in_data=+7 -> out_data=2; in_data=-6 -> out_data=-1 (i.e. 8'hFF); latency exactly 2 cycles.
REQ-040 Saturate/ReLU: shift=0, in_data=300 -> 127; in_data=-300 -> -128; relu=1, in_data=-5 -> 0.
REQ-041 Fill: out_ready=0, push 20 values -> in_ready low after 16 stored, count=16, overflow=1; drain yields first 16 in order.
REQ-042 Full throughput: in_valid=out_ready=1 for 40 cycles -> 1 transfer/cycle, count steady, pointers wrap, in_last on every 8th matches.
REQ-043 Flush with FIFO holding 5 entries plus a simultaneous push -> next cycle count=0, out_valid=0, overflow=0.
REQ-044 Assert rst_n=0 between clock edges with 3 entries -> outputs zero immediately; after release, out_valid stays 0 until new input.
